// File: rtl/dio_slot_bank.sv
// dio_slot_bank: a bank of SLOTS general-purpose I/O slots behind a simple
// register bus. Each slot has WIDTH pads, an output latch, direction control,
// a synchronised input view and per-bit rising/falling edge interrupts.
// Register address = slot + SLOTS * index, with these indices:
// 0 OUT, 1 IN, 2 DIR, 3 PEND, 4 MASK, 5 CLR, 6 RISE, 7 FALL.
module dio_slot_bank #(
    parameter int SLOTS  = 2,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 7
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic                     bus_we,
    input  logic                     bus_re,
    input  logic [WIDTH-1:0]         bus_wdata,
    output logic [WIDTH-1:0]         bus_rdata,
    output logic                     bus_rvalid,
    input  logic [SLOTS*WIDTH-1:0]   pad_i,
    output logic [SLOTS*WIDTH-1:0]   pad_o,
    output logic [SLOTS*WIDTH-1:0]   pad_oe,
    output logic                     irq
);

    // Register indices within a slot.
    localparam int REG_OUT  = 0;
    localparam int REG_IN   = 1;
    localparam int REG_DIR  = 2;
    localparam int REG_PEND = 3;
    localparam int REG_MASK = 4;
    localparam int REG_CLR  = 5;
    localparam int REG_RISE = 6;
    localparam int REG_FALL = 7;

    // Flattened per-slot register views used by the shared read mux and irq.
    logic [SLOTS*WIDTH-1:0] out_flat;
    logic [SLOTS*WIDTH-1:0] in_flat;
    logic [SLOTS*WIDTH-1:0] dir_flat;
    logic [SLOTS*WIDTH-1:0] pend_flat;
    logic [SLOTS*WIDTH-1:0] mask_flat;
    logic [SLOTS*WIDTH-1:0] rise_flat;
    logic [SLOTS*WIDTH-1:0] fall_flat;

    // ------------------------------------------------------------------
    // Edge-detect guard: after reset the synchroniser and prev flops hold
    // zeros, so a pad already high would look like a rising edge. Edges are
    // ignored until prev has been loaded with a genuine sync2 value.
    // ------------------------------------------------------------------
    logic [1:0] guard_q, guard_d;
    logic       edge_en;

    // Guard counter counts down from 3 once reset is released.
    always_comb begin
        guard_d = guard_q;
        if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
        end
    end

    // Guard counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            guard_q <= 2'd3;
        end else begin
            guard_q <= guard_d;
        end
    end

    assign edge_en = (guard_q == 2'd0);

    // ------------------------------------------------------------------
    // Per-slot register file, synchroniser and edge logic.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [WIDTH-1:0] out_q,   out_d;
            logic [WIDTH-1:0] dir_q,   dir_d;
            logic [WIDTH-1:0] mask_q,  mask_d;
            logic [WIDTH-1:0] rise_q,  rise_d;
            logic [WIDTH-1:0] fall_q,  fall_d;
            logic [WIDTH-1:0] pend_q,  pend_d;
            logic [WIDTH-1:0] sync1_q, sync1_d;
            logic [WIDTH-1:0] sync2_q, sync2_d;
            logic [WIDTH-1:0] prev_q,  prev_d;

            logic             wr_out;
            logic             wr_dir;
            logic             wr_mask;
            logic             wr_clr;
            logic             wr_rise;
            logic             wr_fall;
            logic [WIDTH-1:0] rise_det;
            logic [WIDTH-1:0] fall_det;
            logic [WIDTH-1:0] pend_set;
            logic [WIDTH-1:0] pend_clr;

            // Write decode: each strobe hits exactly one register of this slot.
            assign wr_out  = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_OUT));
            assign wr_dir  = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_DIR));
            assign wr_mask = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_MASK));
            assign wr_clr  = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_CLR));
            assign wr_rise = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_RISE));
            assign wr_fall = bus_we && (bus_addr == ADDR_W'(gi + SLOTS * REG_FALL));

            // Edges compare the synchronised value against its previous sample.
            assign rise_det = sync2_q & ~prev_q & {WIDTH{edge_en}};
            assign fall_det = ~sync2_q & prev_q & {WIDTH{edge_en}};
            assign pend_set = (rise_det & rise_q) | (fall_det & fall_q);
            assign pend_clr = wr_clr ? bus_wdata : '0;

            // Next-state for the slot registers; a new edge beats a clear.
            always_comb begin
                out_d   = wr_out  ? bus_wdata : out_q;
                dir_d   = wr_dir  ? bus_wdata : dir_q;
                mask_d  = wr_mask ? bus_wdata : mask_q;
                rise_d  = wr_rise ? bus_wdata : rise_q;
                fall_d  = wr_fall ? bus_wdata : fall_q;
                pend_d  = (pend_q & ~pend_clr) | pend_set;
                sync1_d = pad_i[gi*WIDTH +: WIDTH];
                sync2_d = sync1_q;
                prev_d  = sync2_q;
            end

            // Slot state registers; RISE defaults to all edges enabled.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    out_q   <= '0;
                    dir_q   <= '0;
                    mask_q  <= '0;
                    rise_q  <= '1;
                    fall_q  <= '0;
                    pend_q  <= '0;
                    sync1_q <= '0;
                    sync2_q <= '0;
                    prev_q  <= '0;
                end else begin
                    out_q   <= out_d;
                    dir_q   <= dir_d;
                    mask_q  <= mask_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                    pend_q  <= pend_d;
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    prev_q  <= prev_d;
                end
            end

            assign out_flat[gi*WIDTH +: WIDTH]  = out_q;
            assign in_flat[gi*WIDTH +: WIDTH]   = sync2_q;
            assign dir_flat[gi*WIDTH +: WIDTH]  = dir_q;
            assign pend_flat[gi*WIDTH +: WIDTH] = pend_q;
            assign mask_flat[gi*WIDTH +: WIDTH] = mask_q;
            assign rise_flat[gi*WIDTH +: WIDTH] = rise_q;
            assign fall_flat[gi*WIDTH +: WIDTH] = fall_q;
        end
    endgenerate

    // Pads follow the registered OUT/DIR values directly.
    assign pad_o  = out_flat;
    assign pad_oe = dir_flat;

    // ------------------------------------------------------------------
    // Read path: one-cycle registered response.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Read mux over all mapped registers; CLR and unmapped addresses give 0.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = bus_re;
        for (int s = 0; s < SLOTS; s++) begin
            if (bus_addr == ADDR_W'(s + SLOTS * REG_OUT))  rdata_d = out_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_IN))   rdata_d = in_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_DIR))  rdata_d = dir_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_PEND)) rdata_d = pend_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_MASK)) rdata_d = mask_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_RISE)) rdata_d = rise_flat[s*WIDTH +: WIDTH];
            if (bus_addr == ADDR_W'(s + SLOTS * REG_FALL)) rdata_d = fall_flat[s*WIDTH +: WIDTH];
        end
        if (!bus_re) begin
            rdata_d = rdata_q;
        end
    end

    // Read data holds its last value; rvalid is a single-cycle strobe.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

    // ------------------------------------------------------------------
    // Interrupt: registered OR of masked pending bits across all slots.
    // ------------------------------------------------------------------
    logic irq_q, irq_d;

    // Masked pending reduction.
    always_comb begin
        irq_d = |(pend_flat & mask_flat);
    end

    // Interrupt register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_dio_slot_bank.sv
// Directed testbench for dio_slot_bank (SLOTS=2, WIDTH=16, ADDR_W=7).
// Address map with two slots: OUT 0/1, IN 2/3, DIR 4/5, PEND 6/7,
// MASK 8/9, CLR 10/11, RISE 12/13, FALL 14/15, unmapped >= 16.
module tb_dio_slot_bank;
    localparam int SLOTS  = 2;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 7;

    logic                   sys_clk = 1'b0;
    logic                   sys_rst = 1'b1;
    logic [ADDR_W-1:0]      bus_addr = '0;
    logic                   bus_we = 1'b0;
    logic                   bus_re = 1'b0;
    logic [WIDTH-1:0]       bus_wdata = '0;
    logic [WIDTH-1:0]       bus_rdata;
    logic                   bus_rvalid;
    logic [SLOTS*WIDTH-1:0] pad_i = '0;
    logic [SLOTS*WIDTH-1:0] pad_o;
    logic [SLOTS*WIDTH-1:0] pad_oe;
    logic                   irq;

    dio_slot_bank #(.SLOTS(SLOTS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .pad_i      (pad_i),
        .pad_o      (pad_o),
        .pad_oe     (pad_oe),
        .irq        (irq)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    typedef enum int {K_WR, K_RD, K_PAD, K_IDLE, K_IRQ, K_PO, K_POE} kind_t;
    typedef struct {
        kind_t       kind;
        logic [6:0]  addr;
        logic [31:0] data;   // write data or pad value
        logic [31:0] exp;    // expected rdata / irq / pad vector
        int          n;      // wait cycles for K_PAD / K_IDLE
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic do_write(input logic [6:0] a, input logic [15:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge sys_clk);
        bus_we    = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [15:0] exp, input string name);
        bus_addr = a;
        bus_re   = 1'b1;
        @(negedge sys_clk);
        bus_re   = 1'b0;
        check({name, " rvalid"}, {31'b0, bus_rvalid}, 32'h1);
        check({name, " rdata"}, {16'b0, bus_rdata}, {16'b0, exp});
    endtask

    initial begin
        // Reset with a read strobe and a pad already high on slot 1 bit 15.
        pad_i   = 32'h8000_0000;
        bus_re  = 1'b1;
        bus_addr = 7'd12;
        tick(3);
        check("rst rvalid", {31'b0, bus_rvalid}, 32'h0);
        check("rst rdata", {16'b0, bus_rdata}, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);
        check("rst pad_o", pad_o, 32'h0);
        check("rst pad_oe", pad_oe, 32'h0);
        bus_re  = 1'b0;
        sys_rst = 1'b0;

        // Post-reset defaults and edge-suppression after release
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         4});
        vecs.push_back('{K_RD,   7'd7,  32'h0,         32'h0000,      0});
        vecs.push_back('{K_RD,   7'd12, 32'h0,         32'hFFFF,      0});
        vecs.push_back('{K_RD,   7'd14, 32'h0,         32'h0000,      0});
        vecs.push_back('{K_RD,   7'd3,  32'h0,         32'h8000,      0});
        // Register access, unmapped and read-only addresses
        vecs.push_back('{K_WR,   7'd1,  32'hAAAA,      32'h0,         0});
        vecs.push_back('{K_RD,   7'd1,  32'h0,         32'hAAAA,      0});
        vecs.push_back('{K_RD,   7'd16, 32'h0,         32'h0000,      0});
        vecs.push_back('{K_RD,   7'd127,32'h0,         32'h0000,      0});
        vecs.push_back('{K_WR,   7'd16, 32'h1234,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd3,  32'hFFFF,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd6,  32'hFFFF,      32'h0,         0});
        vecs.push_back('{K_RD,   7'd3,  32'h0,         32'h8000,      0});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h0000,      0});
        vecs.push_back('{K_RD,   7'd10, 32'h0,         32'h0000,      0});
        // Direction and output drive
        vecs.push_back('{K_WR,   7'd1,  32'h0000,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd4,  32'hFFFF,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd0,  32'h5555,      32'h0,         0});
        vecs.push_back('{K_PO,   7'd0,  32'h0,         32'h0000_5555, 0});
        vecs.push_back('{K_POE,  7'd0,  32'h0,         32'h0000_FFFF, 0});
        // Input read; the rising edges also latch PEND while unmasked
        vecs.push_back('{K_PAD,  7'd0,  32'h8000_8001, 32'h0,         3});
        vecs.push_back('{K_RD,   7'd2,  32'h0,         32'h8001,      0});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h8001,      0});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        // Rising-edge interrupt on slot 0 bit 0
        vecs.push_back('{K_WR,   7'd8,  32'hFFFF,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd10, 32'hFFFF,      32'h0,         0});
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         1});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        vecs.push_back('{K_PAD,  7'd0,  32'h8000_8000, 32'h0,         4});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h0000,      0});
        vecs.push_back('{K_PAD,  7'd0,  32'h8000_8001, 32'h0,         3});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         1});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h1,         0});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h0001,      0});
        vecs.push_back('{K_WR,   7'd10, 32'h0001,      32'h0,         0});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h1,         0});
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         1});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h0000,      0});
        // Falling edge on slot 1 bit 2 with masking
        vecs.push_back('{K_WR,   7'd13, 32'h0000,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd15, 32'h0004,      32'h0,         0});
        vecs.push_back('{K_WR,   7'd9,  32'h0000,      32'h0,         0});
        vecs.push_back('{K_PAD,  7'd0,  32'h8004_8001, 32'h0,         5});
        vecs.push_back('{K_RD,   7'd7,  32'h0,         32'h0000,      0});
        vecs.push_back('{K_PAD,  7'd0,  32'h8000_8001, 32'h0,         5});
        vecs.push_back('{K_RD,   7'd7,  32'h0,         32'h0004,      0});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        vecs.push_back('{K_WR,   7'd9,  32'h0004,      32'h0,         0});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         1});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h1,         0});
        vecs.push_back('{K_RD,   7'd7,  32'h0,         32'h0004,      0});
        vecs.push_back('{K_RD,   7'd6,  32'h0,         32'h0000,      0});
        vecs.push_back('{K_WR,   7'd11, 32'h0004,      32'h0,         0});
        vecs.push_back('{K_IDLE, 7'd0,  32'h0,         32'h0,         2});
        vecs.push_back('{K_IRQ,  7'd0,  32'h0,         32'h0,         0});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].kind)
                K_WR:   do_write(vecs[i].addr, vecs[i].data[15:0]);
                K_RD:   do_read(vecs[i].addr, vecs[i].exp[15:0], nm);
                K_PAD:  begin pad_i = vecs[i].data; tick(vecs[i].n); end
                K_IDLE: tick(vecs[i].n);
                K_IRQ:  check({nm, " irq"}, {31'b0, irq}, vecs[i].exp);
                K_PO:   check({nm, " pad_o"}, pad_o, vecs[i].exp);
                K_POE:  check({nm, " pad_oe"}, pad_oe, vecs[i].exp);
                default: ;
            endcase
        end

        // rvalid is a single-cycle pulse
        tick(1);
        check("rvalid drop", {31'b0, bus_rvalid}, 32'h0);

        // Simultaneous write and read returns the pre-write value
        bus_addr  = 7'd0;
        bus_wdata = 16'h1111;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        @(negedge sys_clk);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        check("rw rvalid", {31'b0, bus_rvalid}, 32'h1);
        check("rw old data", {16'b0, bus_rdata}, 32'h5555);
        check("rw pad_o", pad_o, 32'h0000_1111);
        do_read(7'd0, 16'h1111, "rw new data");

        // CLR on the same edge that latches a new rising edge on slot 0 bit 1
        pad_i = 32'h8000_8003;
        tick(2);
        bus_addr  = 7'd10;
        bus_wdata = 16'h0002;
        bus_we    = 1'b1;
        @(negedge sys_clk);
        bus_we    = 1'b0;
        do_read(7'd6, 16'h0002, "collision pend");
        check("collision irq", {31'b0, irq}, 32'h1);

        // Reset mid-operation, with a coincident read strobe
        sys_rst  = 1'b1;
        bus_re   = 1'b1;
        bus_addr = 7'd0;
        @(negedge sys_clk);
        check("mid rst rvalid", {31'b0, bus_rvalid}, 32'h0);
        check("mid rst rdata", {16'b0, bus_rdata}, 32'h0);
        check("mid rst irq", {31'b0, irq}, 32'h0);
        check("mid rst pad_o", pad_o, 32'h0);
        check("mid rst pad_oe", pad_oe, 32'h0);
        bus_re  = 1'b0;
        sys_rst = 1'b0;
        tick(5);
        do_read(7'd12, 16'hFFFF, "post rst rise0");
        do_read(7'd13, 16'hFFFF, "post rst rise1");
        do_read(7'd6, 16'h0000, "post rst pend0");
        do_read(7'd7, 16'h0000, "post rst pend1");
        do_read(7'd0, 16'h0000, "post rst out0");
        do_read(7'd8, 16'h0000, "post rst mask0");
        check("post rst irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
